// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: FSM encoding,
// register-file constants and the load-use hazard predicate.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      IO_WAIT = 2'd1,
      IO_DONE = 2'd2
   } state_e;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

   // x0 is never a real producer, so a load targeting it cannot create a hazard.
   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       id_uses_rs2
   );
      return ex_mem_read && (ex_rd != REG_ZERO) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
   endfunction

endpackage

// File: rtl/conf_debounce.sv
// Confirm-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module conf_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic conf_i,
   output logic conf_pulse
);

   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync       <= 2'b00;
         level      <= 1'b0;
         cnt        <= '0;
         conf_pulse <= 1'b0;
      end else begin
         sync       <= {sync[0], conf_i};
         conf_pulse <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level      <= sync[1];
            cnt        <= '0;
            conf_pulse <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, branch-flush and IO-wait sequencer for the 5-stage pipeline, with
// saturating stall/flush event counters.
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             branch_taken,
   input  logic             mem_io_read,
   input  logic             conf_i,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             io_sample,
   output logic             io_waiting,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e state;
   logic   conf_pulse;
   logic   hazard;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   conf_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_conf_debounce (
      .clk       (clk),
      .rst       (rst),
      .conf_i    (conf_i),
      .conf_pulse(conf_pulse)
   );

   assign hazard = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2);

   // Outputs are forced to their idle values while rst is held.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      io_sample    = 1'b0;
      io_waiting   = 1'b0;
      if (!rst) begin
         unique case (state)
            IO_WAIT: begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               io_waiting   = 1'b1;
            end
            RUN, IO_DONE: begin
               io_sample = (state == IO_DONE);
               if (hazard) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end else if (branch_taken) begin
                  ifid_flush = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         unique case (state)
            RUN:     if (mem_io_read) state <= IO_WAIT;
            IO_WAIT: if (conf_pulse) state <= IO_DONE;
            IO_DONE: state <= RUN;
            default: state <= RUN;
         endcase
         if (idex_flush) stall_cnt <= sat_inc(stall_cnt);
         if (ifid_flush) flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short debounce window and a second
// narrow-counter instance for saturation.
module tb_pipeline_ctrl;

   localparam int DB = 4;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs2, ex_mem_read, branch_taken, mem_io_read, conf_i;

   logic        pc_en, ifid_en, idex_en, exmem_en;
   logic        ifid_flush, idex_flush, memwb_bubble, io_sample, io_waiting;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en;
   logic        s_ifid_flush, s_idex_flush, s_memwb_bubble, s_io_sample, s_io_waiting;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;
   int n_sample = 0;
   int lat;

   pipeline_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_io_read(mem_io_read), .conf_i(conf_i), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .io_sample(io_sample),
      .io_waiting(io_waiting), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_io_read(mem_io_read), .conf_i(conf_i), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
      .idex_en(s_idex_en), .exmem_en(s_exmem_en), .ifid_flush(s_ifid_flush),
      .idex_flush(s_idex_flush), .memwb_bubble(s_memwb_bubble), .io_sample(s_io_sample),
      .io_waiting(s_io_waiting), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (io_sample === 1'b1) n_sample++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; mem_io_read = 1'b0;
   endtask

   task automatic wait_sample(output int l);
      l = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (io_sample) begin
            l = i;
            break;
         end
      end
   endtask

   initial begin
      idle();
      conf_i = 1'b0;
      rst    = 1'b1;
      #3;
      check("rst_pc_en", pc_en, 1);
      check("rst_exmem_en", exmem_en, 1);
      check("rst_bubble", memwb_bubble, 0);
      check("rst_io_waiting", io_waiting, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;

      // Load-use on rs1
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
      #1;
      check("lu_pc_en", pc_en, 0);
      check("lu_ifid_en", ifid_en, 0);
      check("lu_idex_flush", idex_flush, 1);
      check("lu_idex_en", idex_en, 1);
      tick(1);
      check("lu_stall_cnt", stall_cnt, 1);
      idle();
      #1;
      check("lu_cleared_pc_en", pc_en, 1);
      // ex_rd = x0 never stalls
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
      #1;
      check("x0_pc_en", pc_en, 1);
      check("x0_idex_flush", idex_flush, 0);
      // rs2 match ignored when rs2 not used
      ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
      #1;
      check("rs2_unused_flush", idex_flush, 0);
      tick(1);
      check("no_stall_cnt", stall_cnt, 1);

      // Branch alone, then branch with rs2 hazard
      idle();
      branch_taken = 1'b1;
      #1;
      check("br_ifid_flush", ifid_flush, 1);
      check("br_pc_en", pc_en, 1);
      tick(1);
      check("br_flush_cnt", flush_cnt, 1);
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
      #1;
      check("brhz_ifid_flush", ifid_flush, 0);
      check("brhz_idex_flush", idex_flush, 1);
      check("brhz_pc_en", pc_en, 0);
      tick(1);
      check("brhz_flush_cnt", flush_cnt, 1);
      check("brhz_stall_cnt", stall_cnt, 2);

      // IO wait and release
      idle();
      mem_io_read = 1'b1;
      #1;
      check("io_pre_waiting", io_waiting, 0);
      tick(1);
      check("io_waiting", io_waiting, 1);
      check("io_pc_en", pc_en, 0);
      check("io_ifid_en", ifid_en, 0);
      check("io_idex_en", idex_en, 0);
      check("io_exmem_en", exmem_en, 0);
      check("io_bubble", memwb_bubble, 1);
      ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; branch_taken = 1'b1;
      #1;
      check("io_no_idex_flush", idex_flush, 0);
      check("io_no_ifid_flush", ifid_flush, 0);
      tick(1);
      check("io_stall_frozen", stall_cnt, 2);
      check("io_flush_frozen", flush_cnt, 1);
      ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; branch_taken = 1'b0;
      conf_i = 1'b1;
      wait_sample(lat);
      check("io_latency", lat, 7);
      check("done_io_waiting", io_waiting, 0);
      check("done_exmem_en", exmem_en, 1);
      check("done_bubble", memwb_bubble, 0);
      mem_io_read = 1'b0;
      tick(1);
      check("done_to_run_sample", io_sample, 0);
      check("done_to_run_pc_en", pc_en, 1);
      tick(4);
      check("io_sample_count", n_sample, 1);

      // Button already high when entering IO_WAIT
      mem_io_read = 1'b1;
      tick(1);
      tick(8);
      check("held_waiting", io_waiting, 1);
      conf_i = 1'b0;
      tick(2);
      conf_i = 1'b1;
      tick(10);
      check("glitch_waiting", io_waiting, 1);
      check("glitch_no_sample", n_sample, 1);
      conf_i = 1'b0;
      tick(8);
      conf_i = 1'b1;
      wait_sample(lat);
      check("rearm_latency", lat, 7);
      mem_io_read = 1'b0;
      tick(1);
      check("rearm_sample_count", n_sample, 2);

      // Asynchronous reset in IO_WAIT
      conf_i = 1'b0;
      tick(8);
      mem_io_read = 1'b1;
      tick(1);
      check("pre_rst_waiting", io_waiting, 1);
      conf_i = 1'b1;
      tick(3);
      #2;
      rst = 1'b1;
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
      #1;
      check("arst_waiting", io_waiting, 0);
      check("arst_stall_cnt", stall_cnt, 0);
      check("arst_flush_cnt", flush_cnt, 0);
      check("arst_pc_en", pc_en, 1);
      check("arst_idex_flush", idex_flush, 0);
      check("arst_bubble", memwb_bubble, 0);
      idle();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      tick(12);
      check("arst_no_sample", n_sample, 2);
      check("arst_run", io_waiting, 0);

      // Saturation with a 4-bit counter
      ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12;
      tick(20);
      check("sat_stall_cnt", s_stall_cnt, 15);
      check("wide_stall_cnt", stall_cnt, 20);
      check("sat_pc_en", s_pc_en, 0);
      idle();
      tick(2);
      check("sat_hold", s_stall_cnt, 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall sequencer for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB). It detects load-use hazards between the EX and ID stages, flushes IF/ID on taken branches or jumps, and freezes the whole pipeline while a MEM-stage IO read waits for the operator's confirm button. It drives the enable and flush inputs of the IF, IFID, IDEX, EXMEM and MEMWB registers. It also keeps saturating performance counters for stalls and flushes.

## Interface
- DEBOUNCE_CYCLES, 100000 — number of consecutive stable synchronized samples required before conf_i is accepted.
- CNT_W, 16 — width of each performance counter.

- clk  in  1  — CPU clock (cpuclk domain).
- rst  in  1  — asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  — source registers of the instruction in ID.
- id_uses_rs2  in  1  — ID instruction reads rs2 (R/S/B types).
- ex_mem_read  in  1  — EX instruction is a load (memory or IO).
- ex_rd  in  5  — EX destination register.
- branch_taken  in  1  — ID resolved a taken branch or jump (PCSrc).
- mem_io_read  in  1  — MEM instruction is an IO read.
- conf_i  in  1  — raw confirm button, asynchronous.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  — stage-register hold when 0.
- ifid_flush, idex_flush, memwb_bubble  out  1 each  — load NOP/zero controls.
- io_sample  out  1  — one-cycle strobe: capture IO data into MEMWB.
- io_waiting  out  1  — state == IO_WAIT (for LED indication).
- stall_cnt, flush_cnt  out  CNT_W each  — saturating event counters.

## Operation
- FSM states are RUN, IO_WAIT, IO_DONE. Reset state is RUN.
- **RUN → IO_WAIT:** when mem_io_read=1.
- **IO_WAIT → IO_DONE:** on conf_pulse, the debounced rising edge of conf_i.
- **IO_DONE → RUN:** unconditionally.
- **IO_WAIT:**
  - All enables are 0 and memwb_bubble=1.
  - No flushes are issued.
  - Hazard and branch inputs are ignored.
- **IO_DONE:**
  - All enables are 1 and io_sample=1. The IO instruction advances into MEMWB with the sampled data.
  - Hazard and branch logic applies as in RUN, except that mem_io_read is ignored this cycle.
- **Load-use hazard (RUN/IO_DONE):** hazard = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
  - On hazard: pc_en=0, ifid_en=0, idex_flush=1.
  - stall_cnt increments.
- **Branch (RUN/IO_DONE):** branch_taken & !hazard gives ifid_flush=1, and flush_cnt increments.
- **Priority:** IO_WAIT > load-use > branch. When a branch and a hazard coincide, the stall wins and the branch re-resolves next cycle.
- **Debouncer:**
  - conf_i passes through a 2-FF synchronizer, then a stability counter.
  - The stable level updates after DEBOUNCE_CYCLES identical samples.
  - conf_pulse fires for 1 cycle on the stable level's 0→1 transition.
- **Counters:** CNT_W bits, saturate at all-ones, no wrap.

## Timing
- All hazard and flush outputs are combinational from the current state and inputs, and take effect on the next clk edge.
- The FSM and counters update on posedge clk.
- Reset, asynchronous at any time, sets:
  - state=RUN, both counters=0, synchronizer=0, stable level=0, debounce counter=0;
  - outputs pc_en=ifid_en=idex_en=exmem_en=1, all flushes/bubble=0, io_sample=0, io_waiting=0.
- **Load-use:** exactly 1 stall cycle per hazard.
- **IO latency:** an IO read occupies MEM for N+1 cycles, where N is the number of cycles until conf_pulse.
  - Minimum N is 1: IO_WAIT is entered, the pulse arrives, then 1 cycle in IO_DONE.
- **Button handling:**
  - A button already held high when IO_WAIT is entered does not release it; a fresh 0→1 stable edge is required.
  - conf_pulse seen during RUN or IO_DONE is discarded.
- A reset during IO_WAIT returns to RUN with no io_sample.
- A glitch on conf_i shorter than DEBOUNCE_CYCLES produces no pulse.

## Structure
- A shared package `pipe_pkg` holds:
  - the state encoding (RUN=2'd0, IO_WAIT=2'd1, IO_DONE=2'd2);
  - the constant REG_ZERO=5'd0;
  - the NOP instruction constant 32'h00000013 used by the flush/bubble consumers.
- One sub-module, `conf_debounce` (synchronizer, stability counter, edge pulse), parameterized by DEBOUNCE_CYCLES.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4.
1. **Load-use:** ex_mem_read=1, ex_rd=5, id_rs1=5 → pc_en=ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt=1. Repeat with ex_rd=0 → no stall.
2. **Branch and hazard:**
   - branch_taken=1 with no hazard → ifid_flush=1, flush_cnt=1.
   - Add a hazard on id_rs2 with id_uses_rs2=1 → stall only, flush_cnt unchanged.
3. **IO wait:**
   - mem_io_read=1 → io_waiting=1 and all enables 0 from the next cycle.
   - Raise conf_i and hold 10 cycles → exactly one io_sample, after 2 sync + 4 stable cycles + 1 transition to IO_DONE, then RUN.
4. **Button held/glitch:**
   - conf_i already high entering IO_WAIT → stays in IO_WAIT.
   - A 2-cycle low glitch → no pulse.
   - A low then high of ≥4 cycles each → release.
5. **Reset mid-IO_WAIT:** assert rst asynchronously → state=RUN, counters 0, io_sample never asserted.
6. **Saturation:** with CNT_W=4, force 20 load-use stalls → stall_cnt holds at 15.
